// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - buffered decode/issue stage with pending-write scoreboard
// Optional writeback bypass of single-pending sources: define DECODE_WB_BYPASS_EN.
module decode_issue_stage #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN/2,
  parameter int REGISTER_SIZE      = 5,
  parameter int QUEUE_DEPTH        = 4,
  parameter int PEND_CNT_W         = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fd_valid,
  output logic                          fd_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] fd_instruction,
  input  logic [XLEN-1:0]               fd_pc,
  output logic                          de_valid,
  input  logic                          de_ready,
  output logic [INSTRUCTION_LENGTH-1:0] de_instruction,
  output logic [XLEN-1:0]               de_pc,
  output logic [REGISTER_SIZE-1:0]      de_rs1_addr,
  output logic [REGISTER_SIZE-1:0]      de_rs2_addr,
  output logic [REGISTER_SIZE-1:0]      de_rd_addr,
  input  logic                          flush,
  input  logic                          wb_enable,
  input  logic [REGISTER_SIZE-1:0]      wb_addr,
  output logic [$clog2(QUEUE_DEPTH):0]  occupancy,
`ifdef DECODE_WB_BYPASS_EN
  output logic                          de_wb_bypass1,
  output logic                          de_wb_bypass2,
`endif
  output logic                          hazard_stall
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int NREG  = 2**REGISTER_SIZE;
  localparam logic [PEND_CNT_W-1:0] CNT_MAX = '1;

  logic [INSTRUCTION_LENGTH-1:0] instr_q [QUEUE_DEPTH];
  logic [XLEN-1:0]               pc_q    [QUEUE_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [PEND_CNT_W-1:0]         pend_cnt [NREG];

  logic head_present, push, pop, hazard;
  logic use_rs1, use_rs2, use_rd;
  logic rs1_busy, rs2_busy, rs1_byp, rs2_byp, rd_sat;

  assign fd_ready       = rst & (occupancy != OCC_W'(QUEUE_DEPTH));
  assign head_present   = (occupancy != '0);
  assign push           = fd_valid & fd_ready & ~flush;
  assign pop            = de_valid & de_ready;
  assign de_instruction = instr_q[rd_ptr];
  assign de_pc          = pc_q[rd_ptr];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (de_instruction[6:0])
      7'b0110011, 7'b0111011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: use_rd = 1'b1;
      default: ;
    endcase
  end

  assign de_rs1_addr = use_rs1 ? de_instruction[15 +: REGISTER_SIZE] : '0;
  assign de_rs2_addr = use_rs2 ? de_instruction[20 +: REGISTER_SIZE] : '0;
  assign de_rd_addr  = use_rd  ? de_instruction[7  +: REGISTER_SIZE] : '0;

  // pend_cnt[0] is held at 0, so unused fields (address 0) never raise a hazard
  assign rs1_busy = (pend_cnt[de_rs1_addr] != '0);
  assign rs2_busy = (pend_cnt[de_rs2_addr] != '0);
  assign rd_sat   = (pend_cnt[de_rd_addr] == CNT_MAX);

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_byp = wb_enable & (wb_addr == de_rs1_addr) & (pend_cnt[de_rs1_addr] == PEND_CNT_W'(1));
  assign rs2_byp = wb_enable & (wb_addr == de_rs2_addr) & (pend_cnt[de_rs2_addr] == PEND_CNT_W'(1));
  assign de_wb_bypass1 = rs1_byp;
  assign de_wb_bypass2 = rs2_byp;
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign hazard       = (rs1_busy & ~rs1_byp) | (rs2_busy & ~rs2_byp) | rd_sat;
  assign de_valid     = head_present & ~hazard & ~flush;
  assign hazard_stall = head_present & hazard & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= fd_instruction;
      pc_q[wr_ptr]    <= fd_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Flush leaves counters alone: instructions already issued still write back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) pend_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (pop && (de_rd_addr == REGISTER_SIZE'(r)) && !(wb_enable && (wb_addr == REGISTER_SIZE'(r))))
          pend_cnt[r] <= pend_cnt[r] + PEND_CNT_W'(1);
        else if (!(pop && (de_rd_addr == REGISTER_SIZE'(r))) && wb_enable &&
                 (wb_addr == REGISTER_SIZE'(r)) && (pend_cnt[r] != '0))
          pend_cnt[r] <= pend_cnt[r] - PEND_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - directed self-checking bench for decode_issue_stage
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fd_valid, fd_ready;
  logic [31:0] fd_instruction;
  logic [63:0] fd_pc;
  logic        de_valid, de_ready;
  logic [31:0] de_instruction;
  logic [63:0] de_pc;
  logic [4:0]  de_rs1_addr, de_rs2_addr, de_rd_addr;
  logic        flush, wb_enable;
  logic [4:0]  wb_addr;
  logic [2:0]  occupancy;
  logic        hazard_stall;
`ifdef DECODE_WB_BYPASS_EN
  logic        de_wb_bypass1, de_wb_bypass2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst(rst),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_instruction(fd_instruction), .fd_pc(fd_pc),
    .de_valid(de_valid), .de_ready(de_ready), .de_instruction(de_instruction), .de_pc(de_pc),
    .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr), .de_rd_addr(de_rd_addr),
    .flush(flush), .wb_enable(wb_enable), .wb_addr(wb_addr), .occupancy(occupancy),
`ifdef DECODE_WB_BYPASS_EN
    .de_wb_bypass1(de_wb_bypass1), .de_wb_bypass2(de_wb_bypass2),
`endif
    .hazard_stall(hazard_stall)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] f7);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic idle_inputs();
    fd_valid = 1'b0; fd_instruction = '0; fd_pc = '0;
    de_ready = 1'b0; flush = 1'b0; wb_enable = 1'b0; wb_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #12;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL reset_de_valid got=%b exp=0", de_valid); end
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", hazard_stall); end
    total++; if (fd_ready !== 1'b0) begin bad++; $display("FAIL reset_fd_ready got=%b exp=0", fd_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (fd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_fd_ready got=%b exp=1", fd_ready); end
  endtask

  task automatic test_fill_drain();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      fd_valid = 1'b1;
      fd_instruction = enc_i(12'(i), 5'd0, 5'(i + 1));
      fd_pc = 64'h1000 + 64'(4 * i);
      @(negedge clk);
    end
    fd_valid = 1'b0;
    #1;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
    total++; if (fd_ready !== 1'b0) begin bad++; $display("FAIL fill_fd_ready got=%b exp=0", fd_ready); end
    fd_valid = 1'b1; fd_instruction = enc_i(12'd99, 5'd0, 5'd20); fd_pc = 64'h2000;
    @(negedge clk);
    fd_valid = 1'b0;
    #1;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_push_occ got=%0d exp=4", occupancy); end
    total++; if (de_pc !== 64'h1000) begin bad++; $display("FAIL full_push_head_pc got=%h exp=1000", de_pc); end
    de_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, de_valid); end
      total++; if (de_pc !== 64'h1000 + 64'(4 * i)) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, de_pc, 64'h1000 + 64'(4 * i)); end
      total++; if (de_instruction !== enc_i(12'(i), 5'd0, 5'(i + 1))) begin bad++; $display("FAIL drain_instr[%0d] got=%h", i, de_instruction); end
      total++; if (de_rd_addr !== 5'(i + 1)) begin bad++; $display("FAIL drain_rd[%0d] got=%0d exp=%0d", i, de_rd_addr, i + 1); end
      @(negedge clk);
      #1;
    end
    de_ready = 1'b0;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL drain_occ got=%0d exp=0", occupancy); end
    total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got=%b exp=0", de_valid); end
  endtask

  task automatic test_raw();
    do_reset();
    de_ready = 1'b1;
    fd_valid = 1'b1; fd_instruction = enc_r(5'd2, 5'd1, 5'd5, 7'h00); fd_pc = 64'h100;
    @(negedge clk);
    fd_instruction = enc_r(5'd3, 5'd5, 5'd6, 7'h20); fd_pc = 64'h104;
    #1;
    total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL raw_add_valid got=%b exp=1", de_valid); end
    total++; if ({de_rs1_addr, de_rs2_addr, de_rd_addr} !== {5'd1, 5'd2, 5'd5}) begin bad++; $display("FAIL raw_add_fields got=%0d,%0d,%0d exp=1,2,5", de_rs1_addr, de_rs2_addr, de_rd_addr); end
    @(negedge clk);
    fd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_stall[%0d] got=%b exp=1", c, hazard_stall); end
      total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL raw_valid[%0d] got=%b exp=0", c, de_valid); end
      total++; if (de_pc !== 64'h104) begin bad++; $display("FAIL raw_pc[%0d] got=%h exp=104", c, de_pc); end
      @(negedge clk);
    end
    wb_enable = 1'b1; wb_addr = 5'd5;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL raw_wb_valid got=%b exp=1", de_valid); end
    total++; if (de_wb_bypass1 !== 1'b1) begin bad++; $display("FAIL raw_bypass1 got=%b exp=1", de_wb_bypass1); end
    total++; if (de_wb_bypass2 !== 1'b0) begin bad++; $display("FAIL raw_bypass2 got=%b exp=0", de_wb_bypass2); end
`else
    total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL raw_wb_valid got=%b exp=0", de_valid); end
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_wb_stall got=%b exp=1", hazard_stall); end
`endif
    @(negedge clk);
    wb_enable = 1'b0; wb_addr = '0;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL raw_issued_occ got=%0d exp=0", occupancy); end
`else
    total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL raw_release_valid got=%b exp=1", de_valid); end
    total++; if (de_pc !== 64'h104) begin bad++; $display("FAIL raw_release_pc got=%h exp=104", de_pc); end
`endif
    @(negedge clk);
    #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL raw_final_occ got=%0d exp=0", occupancy); end
    de_ready = 1'b0;
  endtask

  task automatic test_waw_saturate();
    do_reset();
    de_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fd_valid = 1'b1; fd_instruction = enc_i(12'(i + 1), 5'd0, 5'd7); fd_pc = 64'h200 + 64'(4 * i);
      @(negedge clk);
    end
    fd_valid = 1'b0;
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%b exp=1", hazard_stall); end
    total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL waw_valid got=%b exp=0", de_valid); end
    total++; if (de_pc !== 64'h20c) begin bad++; $display("FAIL waw_pc got=%h exp=20c", de_pc); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL waw_occ got=%0d exp=1", occupancy); end
    @(negedge clk);
    wb_enable = 1'b1; wb_addr = 5'd7;
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL waw_wb_cycle_stall got=%b exp=1", hazard_stall); end
    @(negedge clk);
    wb_enable = 1'b0; wb_addr = '0;
    #1;
    total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL waw_release_valid got=%b exp=1", de_valid); end
    total++; if (de_rd_addr !== 5'd7) begin bad++; $display("FAIL waw_release_rd got=%0d exp=7", de_rd_addr); end
    @(negedge clk);
    de_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    de_ready = 1'b1;
    fd_valid = 1'b1; fd_instruction = enc_i(12'd1, 5'd0, 5'd9); fd_pc = 64'h300;
    @(negedge clk);
    fd_valid = 1'b0;
    @(negedge clk);
    de_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fd_valid = 1'b1; fd_instruction = enc_i(12'd0, 5'd0, 5'(11 + i)); fd_pc = 64'h310 + 64'(4 * i);
      @(negedge clk);
    end
    #1;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=4", occupancy); end
    flush = 1'b1; de_ready = 1'b1; fd_instruction = enc_i(12'd0, 5'd0, 5'd17); fd_pc = 64'h3f0;
    #1;
    total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL flush_de_valid got=%b exp=0", de_valid); end
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL flush_hazard got=%b exp=0", hazard_stall); end
    @(negedge clk);
    flush = 1'b0; fd_valid = 1'b0; de_ready = 1'b0;
    #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL flush_after_valid got=%b exp=0", de_valid); end
    fd_valid = 1'b1; fd_instruction = enc_i(12'd0, 5'd9, 5'd15); fd_pc = 64'h400;
    @(negedge clk);
    fd_valid = 1'b0;
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL flush_sb_kept got=%b exp=1", hazard_stall); end
    flush = 1'b1; fd_valid = 1'b1; fd_instruction = enc_i(12'd0, 5'd0, 5'd18); fd_pc = 64'h404;
    #1;
    total++; if (fd_ready !== 1'b1) begin bad++; $display("FAIL flush_fd_ready got=%b exp=1", fd_ready); end
    @(negedge clk);
    flush = 1'b0; fd_valid = 1'b0;
    #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_drop_occ got=%0d exp=0", occupancy); end
    fd_valid = 1'b1; fd_instruction = enc_i(12'd0, 5'd11, 5'd16); fd_pc = 64'h408;
    @(negedge clk);
    fd_valid = 1'b0;
    #1;
    total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL flush_no_inc_valid got=%b exp=1", de_valid); end
    total++; if (de_pc !== 64'h408) begin bad++; $display("FAIL flush_no_inc_pc got=%h exp=408", de_pc); end
  endtask

  task automatic test_x0();
    logic [31:0] prog [4];
    logic [4:0]  exp_rd [4];
    prog[0] = enc_s(12'h01f, 5'd0, 5'd0);  exp_rd[0] = 5'd0;
    prog[1] = enc_i(12'd1, 5'd0, 5'd0);    exp_rd[1] = 5'd0;
    prog[2] = 32'hfffff437;                exp_rd[2] = 5'd8;
    prog[3] = enc_r(5'd0, 5'd0, 5'd1, 7'h00); exp_rd[3] = 5'd1;
    do_reset();
    wb_enable = 1'b1; wb_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      fd_valid = 1'b1; fd_instruction = prog[i]; fd_pc = 64'h500 + 64'(4 * i);
      @(negedge clk);
    end
    fd_valid = 1'b0; de_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL x0_valid[%0d] got=%b exp=1", i, de_valid); end
      total++; if (de_rd_addr !== exp_rd[i]) begin bad++; $display("FAIL x0_rd[%0d] got=%0d exp=%0d", i, de_rd_addr, exp_rd[i]); end
      total++; if ({de_rs1_addr, de_rs2_addr} !== 10'd0) begin bad++; $display("FAIL x0_rs[%0d] got=%0d,%0d exp=0,0", i, de_rs1_addr, de_rs2_addr); end
`ifdef DECODE_WB_BYPASS_EN
      total++; if (de_wb_bypass1 !== 1'b0) begin bad++; $display("FAIL x0_bypass1[%0d] got=%b exp=0", i, de_wb_bypass1); end
`endif
      @(negedge clk);
    end
    wb_enable = 1'b0; de_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    de_ready = 1'b1;
    fd_valid = 1'b1; fd_instruction = enc_i(12'd1, 5'd0, 5'd4); fd_pc = 64'h600;
    @(negedge clk);
    fd_valid = 1'b0;
    @(negedge clk);
    de_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fd_valid = 1'b1; fd_instruction = enc_i(12'd0, 5'd0, 5'(20 + i)); fd_pc = 64'h610 + 64'(4 * i);
      @(negedge clk);
    end
    fd_valid = 1'b0;
    #1;
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL mid_pre_occ got=%0d exp=2", occupancy); end
    rst = 1'b0;
    #1;
    total++; if (de_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", de_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL mid_rst_occ got=%0d exp=0", occupancy); end
    @(negedge clk);
    rst = 1'b1;
    fd_valid = 1'b1; fd_instruction = enc_i(12'd0, 5'd4, 5'd22); fd_pc = 64'h700;
    @(negedge clk);
    fd_valid = 1'b0;
    #1;
    total++; if (de_valid !== 1'b1) begin bad++; $display("FAIL mid_after_valid got=%b exp=1", de_valid); end
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL mid_after_hazard got=%b exp=0", hazard_stall); end
    total++; if (de_rs1_addr !== 5'd4) begin bad++; $display("FAIL mid_after_rs1 got=%0d exp=4", de_rs1_addr); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_raw();
    test_waw_saturate();
    test_flush();
    test_x0();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised buffered decode/issue stage placed between the fetch flip-flops and the existing decode/execute path. It queues fetched instructions in a DEPTH-entry FIFO and extracts source and destination registers from the head entry. A per-register pending-write scoreboard stalls RAW and saturated-WAW hazards, and the head is issued to execute over a valid/ready handshake. This replaces the single-cycle enable-based stall scheme with real back-pressure and flush.

## Interface
- XLEN, 64, datapath and PC width
- INSTRUCTION_LENGTH, XLEN/2, instruction width
- REGISTER_SIZE, 5, register address width (2**REGISTER_SIZE registers)
- QUEUE_DEPTH, 4, FIFO entries; power of two, at least 2
- PEND_CNT_W, 2, width of each scoreboard counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- fd_valid  in  1  fetch presents an instruction
- fd_ready  out  1  stage can accept an instruction
- fd_instruction  in  INSTRUCTION_LENGTH  fetched instruction
- fd_pc  in  XLEN  PC of the fetched instruction
- de_valid  out  1  head instruction is issuable
- de_ready  in  1  execute accepts the instruction
- de_instruction  out  INSTRUCTION_LENGTH  head instruction
- de_pc  out  XLEN  head PC
- de_rs1_addr, de_rs2_addr, de_rd_addr  out  REGISTER_SIZE each  decoded fields; 0 when unused
- flush  in  1  redirect from jump/branch; discards all queued instructions
- wb_enable  in  1  writeback retires a register write
- wb_addr  in  REGISTER_SIZE  writeback destination
- occupancy  out  $clog2(QUEUE_DEPTH)+1  queued entry count
- hazard_stall  out  1  head is valid but blocked by the scoreboard

## Operation
- Push: fd_valid & fd_ready. Pop (issue): de_valid & de_ready. Push and pop in the same cycle are allowed; occupancy is unchanged.
- fd_ready = rst & (occupancy != QUEUE_DEPTH). It is 0 when full; no push is ever taken while full.
- Register usage by opcode [6:0]:
  - 0110011, 0111011: rs1, rs2, rd
  - 0010011, 0011011, 0000011, 1100111: rs1, rd
  - 0100011, 1100011: rs1, rs2
  - 0110111, 0010111, 1101111: rd only
  - any other opcode: no registers
- Scoreboard: one PEND_CNT_W-bit counter per register. Register 0 is never tracked and always reads 0.
  - An issue of an instruction writing rd != 0 increments counter[rd].
  - wb_enable with wb_addr != 0 decrements counter[wb_addr]. A decrement at 0 holds 0.
  - An increment and a decrement to the same register in one cycle leave the counter unchanged.
- Hazard, for the head instruction:
  - any used rs has counter != 0, or
  - a used rd has counter at its all-ones maximum.
- de_valid = head present & !hazard & !flush. hazard_stall = head present & hazard & !flush.
- Once de_valid rises, it stays high until a pop or a flush. Counters of sources only fall while waiting.
- Flush has priority over everything else:
  - occupancy goes to 0 and the pointers reset next cycle;
  - any same-cycle push is dropped;
  - any same-cycle pop is suppressed (de_valid forced 0);
  - the scoreboard is untouched, because already-issued instructions still write back.
- Reset (rst low, asynchronous): pointers 0, occupancy 0, all counters 0, de_valid 0, hazard_stall 0, fd_ready 0. Queue storage is not cleared. de_* data outputs are don't-care while de_valid is 0.

## Timing
- Push-to-issue latency: minimum 1 cycle. An entry pushed at edge N is visible at the head and can pop at edge N+1.
- de_valid, de_* fields and hazard_stall are combinational from registered head state, the counters, and flush.
- A writeback at edge N clears the hazard. Without the bypass feature, de_valid rises in the cycle after edge N.
- A counter incremented at edge N blocks a dependent head from cycle N onward. Back-to-back dependent instructions therefore stall until writeback.
- Sustained throughput is 1 instruction/cycle when there are no hazards and de_ready is held high.
- Deasserting rst mid-operation discards all contents. fd_ready rises in the first cycle with rst high.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A source hazard is treated as absent in a cycle where wb_enable & wb_addr == rs and counter[rs] == 1.
  - Added outputs de_wb_bypass1 and de_wb_bypass2 (1 bit each) flag that the operand must come from the writeback data.
  - Bypassed RAW latency is 0 cycles after the writeback cycle.
- Not defined: the bypass outputs are absent, and issue waits for a counter already at 0.

## Test plan
- Reset, then push 4 independent ADDI instructions (opcode 0010011) at QUEUE_DEPTH=4 with de_ready=0.
  - Required: occupancy=4, fd_ready=0.
  - Then raise de_ready: 4 issues on 4 consecutive cycles, in order, with matching PCs.
- Issue ADD x5,x1,x2, then queue SUB x6,x5,x3.
  - Required: hazard_stall=1 and de_valid=0 until wb_enable with wb_addr=5.
  - Issue follows in the next cycle, or in the same cycle with DECODE_WB_BYPASS_EN (de_wb_bypass1=1).
- With PEND_CNT_W=2, issue 3 writes to x7 with no writeback, then present a 4th write to x7.
  - Required: stalled with counter=3. One writeback to x7 releases it.
- Full queue with flush=1 and fd_valid=1 in the same cycle.
  - Required next cycle: occupancy=0, de_valid=0, the pushed instruction is dropped, scoreboard counters unchanged.
- Store to x0 and writebacks to x0.
  - Required: no stall, counter[0] stays 0, and de_rd_addr=0 for the store.
- Assert rst low mid-stream with 2 entries queued and x4 pending.
  - Required: immediate de_valid=0 and occupancy=0. After release, an instruction reading x4 issues without a stall.
